// File: rtl/tlp_rx_arbiter_if.sv
// AXI4-Stream bundle around the TLP receive arbiter: NUM_REQ upstream streams in, one merged stream out.
// The slave modport is the arbiter's view; the master modport is the environment that feeds and drains it.
interface tlp_rx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = 8
);
  logic [NUM_REQ-1:0]        s_axis_tvalid;
  logic [NUM_REQ-1:0]        s_axis_tready;
  logic [NUM_REQ*DATA_W-1:0] s_axis_tdata;
  logic [NUM_REQ*KEEP_W-1:0] s_axis_tkeep;
  logic [NUM_REQ-1:0]        s_axis_tlast;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic [KEEP_W-1:0]         m_axis_tkeep;
  logic                      m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/tlp_rx_arbiter.sv
// Packet-granular round-robin merge of NUM_REQ TLP streams; a grant is held from first beat to tlast.
// Optional stall watchdog enabled by defining TLP_ARB_TIMEOUT_EN.
//   state  | meaning
//   S_IDLE | no grant; outputs quiet; registers the next round-robin winner
//   S_XFER | granted requester's stream passed through combinationally until tlast (or watchdog abort)
module tlp_rx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,
  tlp_rx_arbiter_if.slave            axis,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int NP = 1 << GW;

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [NP-1:0]     vld_pad, lst_pad;
  logic [DATA_W-1:0] dat_arr [NP];
  logic [KEEP_W-1:0] kep_arr [NP];
  logic              pick_found;
  logic [GW-1:0]     pick_idx, cand;
  logic              beat, abort;

  // Pad requester slices to a power of two so the grant index selects with exact width.
  for (genvar i = 0; i < NP; i++) begin : g_pad
    if (i < NUM_REQ) begin : g_real
      assign vld_pad[i] = axis.s_axis_tvalid[i];
      assign lst_pad[i] = axis.s_axis_tlast[i];
      assign dat_arr[i] = axis.s_axis_tdata[i*DATA_W +: DATA_W];
      assign kep_arr[i] = axis.s_axis_tkeep[i*KEEP_W +: KEEP_W];
    end else begin : g_none
      assign vld_pad[i] = 1'b0;
      assign lst_pad[i] = 1'b0;
      assign dat_arr[i] = '0;
      assign kep_arr[i] = '0;
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + GW'(1);
      if (!pick_found && vld_pad[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign beat = vld_pad[grant_q] & axis.m_axis_tready;

`ifdef TLP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_q, stall_d;
  logic          tout_q, tout_d;

  // Only an absent requester counts as a stall; downstream backpressure just holds the count.
  always_comb begin
    stall_d = '0;
    tout_d  = tout_q;
    abort   = 1'b0;
    if (state_q == S_XFER && !vld_pad[grant_q]) begin
      if (stall_q == CW'(TIMEOUT_CYC - 1)) begin
        abort  = 1'b1;
        tout_d = 1'b1;
      end else begin
        stall_d = stall_q + CW'(1);
      end
    end else if (state_q == S_XFER && !beat) begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end

  assign timeout_err = tout_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if ((beat && lst_pad[grant_q]) || abort) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tkeep  = '0;
    axis.m_axis_tlast  = 1'b0;
    axis.s_axis_tready = '0;
    if (state_q == S_XFER) begin
      axis.m_axis_tvalid = vld_pad[grant_q];
      axis.m_axis_tdata  = dat_arr[grant_q];
      axis.m_axis_tkeep  = kep_arr[grant_q];
      axis.m_axis_tlast  = lst_pad[grant_q];
      axis.s_axis_tready = {{(NUM_REQ-1){1'b0}}, axis.m_axis_tready} << grant_q;
    end
  end

  assign busy     = (state_q == S_XFER);
  assign grant_id = grant_q;
endmodule
